fpio_fifo_out: RTL and testbench
================================

FPIO_FIFO_OUT -- requirements
Module: fpio_fifo_out

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 16, number of entries; power of two and at least 2.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, width of each entry in bits.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have port wr_en, input, 1, push request from the producer.
REQ-006 SHALL have port wr_data, input, DATA_WIDTH, push data.
REQ-007 SHALL have port full, output, 1, high when count equals FIFO_DEPTH.
REQ-008 SHALL have port rd_en, input, 1, pop request from the fifo_in_client consumer.
REQ-009 SHALL have port rd_data, output, DATA_WIDTH, head entry; show-ahead, valid whenever empty is low.
REQ-010 SHALL have port empty, output, 1, high when count equals 0.
REQ-011 SHALL have port count, output, $clog2(FIFO_DEPTH)+1, current occupancy.
REQ-012 SHALL have port overflow, output, 1, sticky: a push was attempted while full.
REQ-013 SHALL have port underflow, output, 1, sticky: a pop was attempted while empty.

Function
REQ-014 SHALL accept a push when wr_en=1 and full=0; the data is written at the write pointer, and the pointer advances modulo FIFO_DEPTH.
REQ-015 SHALL accept a pop when rd_en=1 and empty=0; the read pointer advances modulo FIFO_DEPTH.
REQ-016 SHALL present the head entry on rd_data combinationally from storage and the read pointer, so data is poppable one cycle after it is pushed into an empty FIFO.
REQ-017 SHALL, on an accepted push with no accepted pop, increment count by 1; on an accepted pop with no accepted push, decrement it by 1; when both are accepted, or neither, leave count unchanged.
REQ-018 SHALL gate push only on full at the start of the cycle: push when full with a simultaneous pop is rejected; only the pop takes effect.
REQ-019 SHALL gate pop only on empty at the start of the cycle: pop when empty with a simultaneous push is rejected; only the push takes effect.
REQ-020 SHALL leave storage, pointers and count unchanged on a rejected push or pop.
REQ-021 SHALL set overflow on the cycle after a rejected push; it holds until reset.
REQ-022 SHALL set underflow on the cycle after a rejected pop; it holds until reset.
REQ-023 SHALL derive full and empty from count, never from pointer equality alone.
REQ-024 SHALL wrap both pointers from FIFO_DEPTH-1 to 0 without a lost or duplicated entry.

Reset
REQ-025 SHALL, when rst=1 at a clock edge, clear pointers and count to 0; set empty=1, full=0, overflow=0 and underflow=0.
REQ-026 SHALL give rst priority over a simultaneous wr_en or rd_en; storage contents are don't-care after reset.
REQ-027 SHALL, when reset arrives mid-operation, discard all queued entries; no pre-reset data may appear on rd_data afterwards.

Configuration
REQ-028 SHALL, with macro FPIO_FIFO_OUT_ALMOST_FLAGS_EN defined, add parameters AF_LEVEL (default FIFO_DEPTH-2) and AE_LEVEL (default 2).
REQ-029 SHALL, in that configuration, add registered outputs almost_full (count >= AF_LEVEL) and almost_empty (count <= AE_LEVEL), updated in the same cycle as count; after reset almost_full=0 and almost_empty=1.
REQ-030 SHALL, without that macro, omit these parameters and ports; all other behaviour is identical.

Verification
REQ-031 SHALL cover fill and drain: from reset push 16 bytes 0x00..0x0F -> full=1 and count=16; then pop 16 -> rd_data sequence 0x00..0x0F, empty=1 and count=0.
REQ-032 SHALL cover push while full: push 0xAA when count=16 -> overflow=1 next cycle, count stays 16, head unchanged.
REQ-033 SHALL cover pop while empty: rd_en=1 at reset state -> underflow=1, count=0, empty=1.
REQ-034 SHALL cover simultaneous push and pop at count=5 -> count stays 5; pushed value emerges after 5 further pops.
REQ-035 SHALL cover wrap-around: 40 interleaved push/pop pairs with incrementing data -> output order matches input order with no loss.
REQ-036 SHALL cover reset mid-operation: push 3 entries, assert rst one cycle -> empty=1, count=0, overflow=0; the next push of 0x55 appears at the head.

Source files
------------

// File: rtl/fpio_fifo_out.sv
// rtl/fpio_fifo_out.sv - show-ahead synchronous FIFO with sticky overflow/underflow flags.
// Optional almost_full/almost_empty outputs are enabled by defining FPIO_FIFO_OUT_ALMOST_FLAGS_EN.
module fpio_fifo_out #(
  parameter int FIFO_DEPTH = 16,
`ifdef FPIO_FIFO_OUT_ALMOST_FLAGS_EN
  parameter int DATA_WIDTH = 8,
  parameter int AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int AE_LEVEL   = 2
`else
  parameter int DATA_WIDTH = 8
`endif
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          wr_en,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  output logic                          full,
  input  logic                          rd_en,
  output logic [DATA_WIDTH-1:0]         rd_data,
  output logic                          empty,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
`ifdef FPIO_FIFO_OUT_ALMOST_FLAGS_EN
  output logic                          underflow,
  output logic                          almost_full,
  output logic                          almost_empty
`else
  output logic                          underflow
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_nxt;
  logic                  push_ok;
  logic                  pop_ok;

  // Flags come from the occupancy count so a full FIFO is never mistaken for empty.
  assign full    = (count_q == DEPTH_C);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem[rd_ptr];

  // Acceptance uses start-of-cycle full/empty only; a same-cycle pop does not make room.
  assign push_ok = wr_en && !full;
  assign pop_ok  = rd_en && !empty;

  always_comb begin
    count_nxt = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_nxt = count_q + 1'b1;
      2'b01:   count_nxt = count_q - 1'b1;
      default: count_nxt = count_q;
    endcase
  end

  // Storage has no reset; reset only rewinds the pointers and count.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count_q   <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (push_ok) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop_ok) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      count_q <= count_nxt;
      if (wr_en && full) begin
        overflow <= 1'b1;
      end
      if (rd_en && empty) begin
        underflow <= 1'b1;
      end
    end
  end

`ifdef FPIO_FIFO_OUT_ALMOST_FLAGS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= (count_nxt >= CW'(AF_LEVEL));
      almost_empty <= (count_nxt <= CW'(AE_LEVEL));
    end
  end
`else
`endif

endmodule

// File: tb/tb_fpio_fifo_out.sv
// tb/tb_fpio_fifo_out.sv - directed vector and sequence bench for fpio_fifo_out.
module tb_fpio_fifo_out;

  logic       clk;
  logic       rst;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       rd_en;
  logic [7:0] rd_data;
  logic       empty;
  logic [4:0] count;
  logic       overflow;
  logic       underflow;

  int checks;
  int failures;

  fpio_fifo_out #(.FIFO_DEPTH(16), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .wr_en     (wr_en),
    .wr_data   (wr_data),
    .full      (full),
    .rd_en     (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .count     (count),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       r;
    logic       wr;
    logic [7:0] d;
    logic       rd;
    int         exp_count;
    logic       exp_empty;
    logic       exp_full;
    logic       exp_ovf;
    logic       exp_unf;
    logic       chk_data;
    logic [7:0] exp_data;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 ns after the rising edge.
  task automatic step(input logic r, input logic wr, input logic [7:0] d, input logic rd);
    rst     = r;
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    wr_en    = 1'b0;
    wr_data  = 8'h00;
    rd_en    = 1'b0;

    //            r   wr  d      rd  cnt e  f  ov un chk data
    vecs[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3] = '{1'b0, 1'b1, 8'h11, 1'b0, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h11};
    vecs[4] = '{1'b0, 1'b1, 8'h22, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h22};
    vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[6] = '{1'b0, 1'b1, 8'h33, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h33};
    vecs[7] = '{1'b1, 1'b1, 8'h44, 1'b1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};

    for (int i = 0; i < 8; i++) begin
      step(vecs[i].r, vecs[i].wr, vecs[i].d, vecs[i].rd);
      check($sformatf("vec%0d_count", i), 32'(count), 32'(vecs[i].exp_count));
      check($sformatf("vec%0d_empty", i), 32'(empty), 32'(vecs[i].exp_empty));
      check($sformatf("vec%0d_full", i), 32'(full), 32'(vecs[i].exp_full));
      check($sformatf("vec%0d_overflow", i), 32'(overflow), 32'(vecs[i].exp_ovf));
      check($sformatf("vec%0d_underflow", i), 32'(underflow), 32'(vecs[i].exp_unf));
      if (vecs[i].chk_data) begin
        check($sformatf("vec%0d_rd_data", i), 32'(rd_data), 32'(vecs[i].exp_data));
      end
    end

    // Fill to 16, push while full, drain in order.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
    end
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd16);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd16);
    check("ovf_head", 32'(rd_data), 32'h00);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain_head%0d", i), 32'(rd_data), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(empty), 32'd1);
    check("drain_count", 32'(count), 32'd0);
    check("drain_ovf_sticky", 32'(overflow), 32'd1);

    // Reset mid-operation with a competing push discards the queue and sticky flags.
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'hA1 + 8'(i), 1'b0);
    end
    check("mid_count", 32'(count), 32'd3);
    step(1'b1, 1'b1, 8'hEE, 1'b0);
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_overflow", 32'(overflow), 32'd0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    check("rst_head", 32'(rd_data), 32'h55);
    check("rst_push_count", 32'(count), 32'd1);

    // Push with simultaneous pop while full: only the pop is taken.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0);
    end
    step(1'b0, 1'b1, 8'hBB, 1'b1);
    check("fullpp_count", 32'(count), 32'd15);
    check("fullpp_head", 32'(rd_data), 32'h01);
    check("fullpp_ovf", 32'(overflow), 32'd1);

    // Simultaneous push and pop at count=5.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h50 + 8'(i), 1'b0);
    end
    step(1'b0, 1'b1, 8'h99, 1'b1);
    check("pp5_count", 32'(count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("pp5_head%0d", i), 32'(rd_data), 32'h51 + 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    check("pp5_pushed_head", 32'(rd_data), 32'h99);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("pp5_empty", 32'(empty), 32'd1);

    // Wrap-around: 40 interleaved push/pop pairs with one entry in flight.
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      check($sformatf("wrap_head%0d", i), 32'(rd_data), 32'(i));
      step(1'b0, 1'b1, 8'(i + 1), 1'b1);
      check($sformatf("wrap_count%0d", i), 32'(count), 32'd1);
    end
    check("wrap_last", 32'(rd_data), 32'd40);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    check("wrap_empty", 32'(empty), 32'd1);
    check("wrap_no_unf", 32'(underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
